hpm_counter_core: RTL
=====================

HPM_COUNTER_CORE -- requirements
Module: hpm_counter_core

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, counter width in bits (legal 16..32).
REQ-002 The block SHALL have port clk, input, 1, system clock; all logic is synchronous to its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port cs, input, 1, FPro slot select.
REQ-005 The block SHALL have port write, input, 1, write strobe, qualified by cs.
REQ-006 The block SHALL have port read, input, 1, read strobe, qualified by cs; it has no side effect.
REQ-007 The block SHALL have port addr, input, 5, slot register address.
REQ-008 The block SHALL have port wr_data, input, 32, write data.
REQ-009 The block SHALL have port rd_data, output, 32, read data.
REQ-010 The block SHALL have ports probe_inst, probe_mem_rd and probe_mem_wr, input, 1 each, MCS IO addr, read and write strobe probes.

Function
REQ-011 Register map: 0 CTRL (RW); 1 CMD (WO); 2 SNAP_INST; 3 SNAP_RD; 4 SNAP_WR; 5 SNAP_CYC; 6 STATUS (RO); all other addresses read 0.
REQ-012 CTRL[0] SHALL be the global enable, and CTRL[3:1] SHALL be the per-counter enables for inst, rd and wr; other bits read 0.
REQ-013 The cycle counter SHALL increment every clk while CTRL[0]=1.
REQ-014 Event counter k SHALL increment in each cycle where its probe=1, CTRL[0]=1 and CTRL[k]=1; a multi-cycle high level counts once per cycle.
REQ-015 Probes SHALL be sampled with no synchronizer because they share clk; count latency SHALL be 1 cycle (probe high in cycle n gives the counter +1 visible in cycle n+1).
REQ-016 Counters SHALL wrap modulo 2^CNT_W; a wrap SHALL set the sticky STATUS bit (0 cyc, 1 inst, 2 rd, 3 wr).
REQ-017 A write to CMD with wr_data[0]=1 (CLEAR) SHALL zero all counters and STATUS on the next edge; CLEAR SHALL win over a same-cycle increment or wrap.
REQ-018 A write to CMD with wr_data[1]=1 (SNAP) SHALL copy all four live counters into the SNAP registers on the same edge, giving a coherent image.
REQ-019 SNAP SHALL capture the registered pre-edge counter values, so a same-cycle increment is excluded from the snapshot.
REQ-020 When SNAP and CLEAR are written together, the snapshot SHALL hold pre-clear values and the counters SHALL read 0 afterwards.
REQ-021 rd_data SHALL be a combinational mux of addr with zero-extension above CNT_W; rd_data is valid in the same cycle as read.
REQ-022 A write to CTRL SHALL take effect for probe events from the next cycle onward.
REQ-023 Writes to read-only or unmapped addresses SHALL be ignored.

Reset
REQ-024 Asserting reset_n=0 SHALL asynchronously clear CTRL, all counters, all SNAP registers and STATUS to 0, including mid-count; rd_data then reads 0 at every address.
REQ-025 Deassertion SHALL be synchronized externally; after deassertion the block SHALL be idle (disabled) until CTRL is written.

Structure
REQ-026 Package hpm_pkg SHALL hold the register address constants, the CTRL and CMD bit positions, and the STATUS bit indices.
REQ-027 Sub-module hpm_event_counter (CNT_W counter with en, inc, clr, and a wrap pulse output) SHALL be instantiated four times.

Verification
REQ-028 Write CTRL=0xF, drive probe_inst high for 10 cycles, then write SNAP: SNAP_INST=10, SNAP_RD=0, SNAP_WR=0.
REQ-029 Write CTRL=0x5 (inst disabled, rd enabled), pulse probe_inst 3 times and probe_mem_rd 4 times, then write SNAP: SNAP_INST=0 and SNAP_RD=4.
REQ-030 With CNT_W=16, preload rd to 0xFFFF through 65535 events, then give one more event and write SNAP: SNAP_RD=0 and STATUS[2]=1; then write CLEAR: STATUS=0.
REQ-031 Write CMD=0x3 with a probe_mem_wr pulse in the same cycle and the wr counter at 7: SNAP_WR=7, and after a second SNAP, SNAP_WR=0.
REQ-032 Assert reset_n=0 for 1 cycle while counting with CTRL=0xF: all addresses read 0 and CTRL=0 immediately after the reset pulse.

Source files
------------

// File: rtl/hpm_pkg.sv
// Purpose: shared constants for the hardware performance monitor slot.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: register addresses, CTRL/CMD bit positions and STATUS/counter
// indices used by hpm_counter_core and its bench.
package hpm_pkg;

  localparam int ADDR_W = 5;

  // Slot register map
  localparam logic [ADDR_W-1:0] ADDR_CTRL      = 5'd0;
  localparam logic [ADDR_W-1:0] ADDR_CMD       = 5'd1;
  localparam logic [ADDR_W-1:0] ADDR_SNAP_INST = 5'd2;
  localparam logic [ADDR_W-1:0] ADDR_SNAP_RD   = 5'd3;
  localparam logic [ADDR_W-1:0] ADDR_SNAP_WR   = 5'd4;
  localparam logic [ADDR_W-1:0] ADDR_SNAP_CYC  = 5'd5;
  localparam logic [ADDR_W-1:0] ADDR_STATUS    = 5'd6;

  // CTRL bits: global enable plus one enable per event counter
  localparam int CTRL_W        = 4;
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_INST_BIT = 1;
  localparam int CTRL_RD_BIT   = 2;
  localparam int CTRL_WR_BIT   = 3;

  // CMD bits (write-only, self-clearing by nature: they act only in the write cycle)
  localparam int CMD_CLEAR_BIT = 0;
  localparam int CMD_SNAP_BIT  = 1;

  // Counter indices; also the STATUS wrap-bit positions
  localparam int NUM_CNT  = 4;
  localparam int IDX_CYC  = 0;
  localparam int IDX_INST = 1;
  localparam int IDX_RD   = 2;
  localparam int IDX_WR   = 3;

endpackage

// File: rtl/hpm_event_counter.sv
// Purpose: one CNT_W-bit wrapping counter with enable, increment and clear.
// Latency: inc in cycle n is visible on count in cycle n+1.
// Backpressure: none; clr overrides inc and suppresses the wrap pulse.
// Ports: clk, reset_n (async active-low), en, inc, clr -> count, wrap
// (wrap is a combinational pulse in the cycle whose edge rolls count to 0).
module hpm_event_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic bump;
  assign bump = en & inc;

  // A clear in the same cycle means the counter never reaches 0 by wrapping.
  assign wrap = bump & ~clr & (&count);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (bump) begin
      count <= count + CNT_ONE;
    end
  end

endmodule

// File: rtl/hpm_counter_core.sv
// Purpose: FPro-slot performance monitor: cycle, inst, mem-rd and mem-wr counters.
// Latency: probe high in cycle n counts in cycle n+1; rd_data is combinational on addr.
// Backpressure: none; every slot access completes in its own cycle.
// Ports: clk, reset_n; slot bus cs/write/read/addr/wr_data -> rd_data;
// probe_inst/probe_mem_rd/probe_mem_wr event strobes sampled on clk.
module hpm_counter_core
  import hpm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cs,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  input  logic              probe_inst,
  input  logic              probe_mem_rd,
  input  logic              probe_mem_wr
);

  logic [CTRL_W-1:0]  ctrl_q;
  logic [NUM_CNT-1:0] status_q;
  logic [CNT_W-1:0]   live [NUM_CNT];
  logic [CNT_W-1:0]   snap_q [NUM_CNT];
  logic [NUM_CNT-1:0] inc;
  logic [NUM_CNT-1:0] wrap;

  logic wr_en;
  logic ctrl_we;
  logic cmd_we;
  logic do_clear;
  logic do_snap;

  assign wr_en    = cs & write;
  assign ctrl_we  = wr_en & (addr == ADDR_CTRL);
  assign cmd_we   = wr_en & (addr == ADDR_CMD);
  assign do_clear = cmd_we & wr_data[CMD_CLEAR_BIT];
  assign do_snap  = cmd_we & wr_data[CMD_SNAP_BIT];

  // Reads have no side effect and only the low CTRL bits are stored.
  logic unused_ok;
  assign unused_ok = &{1'b0, read, wr_data[31:CTRL_W]};

  // Probes share clk, so they feed the counters directly.
  assign inc[IDX_CYC]  = 1'b1;
  assign inc[IDX_INST] = probe_inst   & ctrl_q[CTRL_INST_BIT];
  assign inc[IDX_RD]   = probe_mem_rd & ctrl_q[CTRL_RD_BIT];
  assign inc[IDX_WR]   = probe_mem_wr & ctrl_q[CTRL_WR_BIT];

  for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
    hpm_event_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (ctrl_q[CTRL_EN_BIT]),
      .inc     (inc[k]),
      .clr     (do_clear),
      .count   (live[k]),
      .wrap    (wrap[k])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q <= '0;
    end else if (ctrl_we) begin
      ctrl_q <= wr_data[CTRL_W-1:0];
    end
  end

  // Wrap flags are sticky until CLEAR; CLEAR beats a same-cycle wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_q <= '0;
    end else if (do_clear) begin
      status_q <= '0;
    end else begin
      status_q <= status_q | wrap;
    end
  end

  // Snapshot takes the registered counter values, so all four come from the
  // same pre-edge instant and a concurrent CLEAR or increment is not seen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CNT; k++) snap_q[k] <= '0;
    end else if (do_snap) begin
      for (int k = 0; k < NUM_CNT; k++) snap_q[k] <= live[k];
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_CTRL:      rd_data[CTRL_W-1:0]  = ctrl_q;
      ADDR_SNAP_INST: rd_data[CNT_W-1:0]   = snap_q[IDX_INST];
      ADDR_SNAP_RD:   rd_data[CNT_W-1:0]   = snap_q[IDX_RD];
      ADDR_SNAP_WR:   rd_data[CNT_W-1:0]   = snap_q[IDX_WR];
      ADDR_SNAP_CYC:  rd_data[CNT_W-1:0]   = snap_q[IDX_CYC];
      ADDR_STATUS:    rd_data[NUM_CNT-1:0] = status_q;
      default:        rd_data = '0;
    endcase
  end

endmodule
